// File: rtl/sram_like_bus_arbiter_if.sv
// Bundled sram-like signals for the inst port, the data port and the shared memory port.
// Handshake: a requester holds req/addr/size/wr/wdata stable until addr_ok is seen high at a
// clock edge; data_ok is a one-cycle pulse that carries rdata for reads or acks a write.
interface sram_like_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [1:0]        i_size;
  logic [ADDR_W-1:0] i_addr;
  logic              i_addr_ok;
  logic              i_data_ok;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_wr;
  logic [1:0]        d_size;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_addr_ok;
  logic              d_data_ok;
  logic [DATA_W-1:0] d_rdata;

  logic              m_req;
  logic              m_wr;
  logic [1:0]        m_size;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_addr_ok;
  logic              m_data_ok;
  logic [DATA_W-1:0] m_rdata;

  // Arbiter view: serves the two CPU ports and drives the shared memory port.
  modport slave (
    input  i_req, i_size, i_addr,
    input  d_req, d_wr, d_size, d_addr, d_wdata,
    input  m_addr_ok, m_data_ok, m_rdata,
    output i_addr_ok, i_data_ok, i_rdata,
    output d_addr_ok, d_data_ok, d_rdata,
    output m_req, m_wr, m_size, m_addr, m_wdata
  );

  // Environment view: CPU requesters plus the memory responder.
  modport master (
    output i_req, i_size, i_addr,
    output d_req, d_wr, d_size, d_addr, d_wdata,
    output m_addr_ok, m_data_ok, m_rdata,
    input  i_addr_ok, i_data_ok, i_rdata,
    input  d_addr_ok, d_data_ok, d_rdata,
    input  m_req, m_wr, m_size, m_addr, m_wdata
  );
endinterface

// File: rtl/sram_like_bus_arbiter.sv
// Two-port to one-port sram-like arbiter: data has priority, inst is protected from starvation,
// and a single transaction is in flight at a time (IDLE -> ADDR -> DATA -> IDLE).
module sram_like_bus_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  sram_like_bus_arbiter_if.slave  bus,
  output logic                    busy,
  output logic [1:0]              state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_I = 2'd1, OWN_D = 2'd2} owner_t;

  localparam int            CW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  state_t        state;
  owner_t        owner;
  logic [CW-1:0] starve_cnt;

  logic starve_hit;
  logic grant_d;
  logic owner_req;
  logic sel_i;
  logic sel_d;
  logic in_addr;
  logic in_data;
  logic ack;
  logic rsp;

  assign starve_hit = (STARVE_MAX != 0) && (starve_cnt == STARVE_LIM);
  assign grant_d    = bus.d_req && !(bus.i_req && starve_hit);
  assign sel_i      = (owner == OWN_I);
  assign sel_d      = (owner == OWN_D);
  assign owner_req  = (sel_d && bus.d_req) || (sel_i && bus.i_req);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_NONE;
      starve_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.d_req || bus.i_req) begin
            state <= ADDR;
            if (grant_d) begin
              owner <= OWN_D;
              if (bus.i_req && (starve_cnt != STARVE_LIM))
                starve_cnt <= starve_cnt + 1'b1;
            end else begin
              owner      <= OWN_I;
              starve_cnt <= '0;
            end
          end
        end
        ADDR: begin
          // A requester withdrawing before acceptance ends the attempt without a handshake.
          if (!owner_req) begin
            state <= IDLE;
            owner <= OWN_NONE;
          end else if (bus.m_addr_ok) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (bus.m_data_ok) begin
            state <= IDLE;
            owner <= OWN_NONE;
          end
        end
        default: begin
          state <= IDLE;
          owner <= OWN_NONE;
        end
      endcase
    end
  end

  assign in_addr = (state == ADDR);
  assign in_data = (state == DATA) && !rst;

  // m_req follows the owner's req so a withdrawn request is never offered to memory.
  assign bus.m_req   = in_addr && owner_req;
  assign bus.m_wr    = in_addr && sel_d && bus.d_wr;
  assign bus.m_size  = in_addr ? (sel_d ? bus.d_size : bus.i_size) : 2'b00;
  assign bus.m_addr  = in_addr ? (sel_d ? bus.d_addr : bus.i_addr) : {ADDR_W{1'b0}};
  assign bus.m_wdata = (in_addr && sel_d) ? bus.d_wdata : {DATA_W{1'b0}};

  // Handshakes are suppressed while rst is high so an aborted transfer is never acknowledged.
  assign ack           = in_addr && owner_req && bus.m_addr_ok && !rst;
  assign bus.i_addr_ok = ack && sel_i;
  assign bus.d_addr_ok = ack && sel_d;

  assign rsp           = in_data && bus.m_data_ok;
  assign bus.i_data_ok = rsp && sel_i;
  assign bus.d_data_ok = rsp && sel_d;
  assign bus.i_rdata   = (rsp && sel_i) ? bus.m_rdata : {DATA_W{1'b0}};
  assign bus.d_rdata   = (rsp && sel_d) ? bus.m_rdata : {DATA_W{1'b0}};

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_sram_like_bus_arbiter.sv
// Bench for sram_like_bus_arbiter: directed scenarios with literal expectations, then random
// traffic compared every cycle against a transaction-level model of the arbitration rules.
module tb_sram_like_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SM = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic [1:0] state_dbg;

  sram_like_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sram_like_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // cur: who owns the transaction in flight (0 none, 1 inst, 2 data); acc: address accepted.
  int cur = 0;
  bit acc = 1'b0;
  int streak = 0;
  int grant_log[$];
  bit i_taken = 1'b0;
  bit d_taken = 1'b0;

  function automatic bit owner_req_now();
    if (cur == 2) return bus.d_req;
    if (cur == 1) return bus.i_req;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      cur = 0; acc = 1'b0; streak = 0;
    end else if (cur == 0) begin
      if (bus.d_req || bus.i_req) begin
        if (bus.d_req && !(bus.i_req && SM != 0 && streak >= SM)) begin
          cur = 2;
          if (bus.i_req) streak++;
        end else begin
          cur = 1;
          streak = 0;
        end
        acc = 1'b0;
        grant_log.push_back(cur);
      end
    end else if (!acc) begin
      if (!owner_req_now()) cur = 0;
      else if (bus.m_addr_ok) begin
        acc = 1'b1;
        if (cur == 1) i_taken = 1'b1; else d_taken = 1'b1;
      end
    end else if (bus.m_data_ok) begin
      cur = 0; acc = 1'b0;
    end
  end

  // ---------------- scoreboard / compare ----------------
  task automatic compare_cycle();
    bit          e_mreq, e_wr, e_iaok, e_daok, e_idok, e_ddok, oreq;
    logic [1:0]  e_size;
    logic [31:0] e_addr, e_wdata, e_ird, e_drd;
    e_mreq = 0; e_wr = 0; e_iaok = 0; e_daok = 0; e_idok = 0; e_ddok = 0;
    e_size = '0; e_addr = '0; e_wdata = '0; e_ird = '0; e_drd = '0;
    oreq = owner_req_now();
    if (cur != 0 && !acc) begin
      e_mreq = oreq;
      e_size = (cur == 2) ? bus.d_size : bus.i_size;
      e_addr = (cur == 2) ? bus.d_addr : bus.i_addr;
      if (cur == 2) begin e_wr = bus.d_wr; e_wdata = bus.d_wdata; end
      if (oreq && bus.m_addr_ok && !rst) begin
        if (cur == 1) e_iaok = 1; else e_daok = 1;
      end
    end
    if (cur != 0 && acc && bus.m_data_ok && !rst) begin
      if (cur == 1) begin e_idok = 1; e_ird = bus.m_rdata; end
      else begin e_ddok = 1; e_drd = bus.m_rdata; end
    end
    check("m_req", bus.m_req, e_mreq);
    check("m_wr", bus.m_wr, e_wr);
    check("m_size", bus.m_size, e_size);
    check("m_addr", bus.m_addr, e_addr);
    check("m_wdata", bus.m_wdata, e_wdata);
    check("i_addr_ok", bus.i_addr_ok, e_iaok);
    check("d_addr_ok", bus.d_addr_ok, e_daok);
    check("i_data_ok", bus.i_data_ok, e_idok);
    check("d_data_ok", bus.d_data_ok, e_ddok);
    check("i_rdata", bus.i_rdata, e_ird);
    check("d_rdata", bus.d_rdata, e_drd);
    check("busy", busy, cur != 0);
  endtask

  always @(negedge clk) begin
    #2;
    if (cmp_en) compare_cycle();
  end

  // Grant-order and data_ok capture for the directed windows.
  bit         capture = 1'b0;
  logic [1:0] dut_grants[$];
  logic [1:0] exp_q[$];
  int         dok_cnt = 0;

  always @(negedge clk) begin
    #3;
    if (capture) begin
      if (bus.i_addr_ok) dut_grants.push_back(2'd1);
      if (bus.d_addr_ok) dut_grants.push_back(2'd2);
      dok_cnt += int'(bus.i_data_ok) + int'(bus.d_data_ok);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_zero();
    bus.i_req = 0; bus.i_size = 0; bus.i_addr = 0;
    bus.d_req = 0; bus.d_wr = 0; bus.d_size = 0; bus.d_addr = 0; bus.d_wdata = 0;
    bus.m_addr_ok = 0; bus.m_data_ok = 0; bus.m_rdata = 0;
  endtask

  task automatic drive_random();
    rst = ($urandom_range(0, 199) == 0);
    if (i_taken) begin i_taken = 0; bus.i_req = 0; end
    if (!bus.i_req && $urandom_range(0, 1) == 1) begin
      bus.i_req  = 1;
      bus.i_addr = $urandom;
      bus.i_size = 2'($urandom_range(0, 2));
    end
    if (d_taken) begin d_taken = 0; bus.d_req = 0; end
    if (!bus.d_req && $urandom_range(0, 1) == 1) begin
      bus.d_req   = 1;
      bus.d_wr    = 1'($urandom_range(0, 1));
      bus.d_addr  = $urandom;
      bus.d_size  = 2'($urandom_range(0, 2));
      bus.d_wdata = $urandom;
    end
    bus.m_addr_ok = ($urandom_range(0, 2) != 0);
    bus.m_data_ok = ($urandom_range(0, 2) == 0);
    bus.m_rdata   = $urandom;
  endtask

  // ---------------- stimulus ----------------
  int log_base;

  initial begin
    rst = 1'b0;
    drive_zero();

    // Reset with both requests pending, then the first grant goes to data.
    tick(); rst = 1; bus.i_req = 1; bus.d_req = 1; bus.i_addr = 32'h100; bus.d_addr = 32'h200;
    tick(); #1;
    check("rst_m_req", bus.m_req, 0); check("rst_busy", busy, 0);
    check("rst_i_addr_ok", bus.i_addr_ok, 0); check("rst_d_addr_ok", bus.d_addr_ok, 0);
    cmp_en = 1;
    tick(); rst = 0; #1; check("post_rst_busy", busy, 0);
    tick(); bus.m_addr_ok = 1; #1;
    check("first_grant_d", bus.d_addr_ok, 1); check("first_grant_not_i", bus.i_addr_ok, 0);
    check("first_grant_addr", bus.m_addr, 32'h200);
    tick(); bus.d_req = 0; bus.m_addr_ok = 0; bus.m_data_ok = 1; bus.m_rdata = 32'h55; #1;
    check("first_d_data_ok", bus.d_data_ok, 1); check("first_d_rdata", bus.d_rdata, 32'h55);
    tick(); bus.i_req = 0; bus.m_data_ok = 0; #1; check("first_idle", busy, 0);

    // Single inst read on a zero-wait bus.
    tick(); bus.i_req = 1; bus.i_addr = 32'hBFC00000; bus.i_size = 2;
    tick(); bus.m_addr_ok = 1; #1;
    check("ifetch_m_req", bus.m_req, 1); check("ifetch_m_addr", bus.m_addr, 32'hBFC00000);
    check("ifetch_m_wr", bus.m_wr, 0); check("ifetch_i_addr_ok", bus.i_addr_ok, 1);
    tick(); bus.i_req = 0; bus.m_addr_ok = 0; bus.m_data_ok = 1; bus.m_rdata = 32'h3C1D0001; #1;
    check("ifetch_i_data_ok", bus.i_data_ok, 1); check("ifetch_i_rdata", bus.i_rdata, 32'h3C1D0001);
    check("ifetch_d_data_ok", bus.d_data_ok, 0); check("ifetch_d_rdata", bus.d_rdata, 0);
    tick(); bus.m_data_ok = 0; #1; check("ifetch_idle", busy, 0);

    // Data store.
    tick(); bus.d_req = 1; bus.d_wr = 1; bus.d_size = 2; bus.d_addr = 32'h80001000; bus.d_wdata = 32'hDEADBEEF;
    tick(); bus.m_addr_ok = 1; #1;
    check("store_m_wr", bus.m_wr, 1); check("store_m_wdata", bus.m_wdata, 32'hDEADBEEF);
    check("store_m_size", bus.m_size, 2); check("store_d_addr_ok", bus.d_addr_ok, 1);
    tick(); bus.d_req = 0; bus.d_wr = 0; bus.d_wdata = 0; bus.m_addr_ok = 0; #1;
    check("store_wait_d_data_ok", bus.d_data_ok, 0); check("store_data_m_req", bus.m_req, 0);
    tick(); bus.m_data_ok = 1; #1;
    check("store_d_data_ok", bus.d_data_ok, 1); check("store_i_data_ok", bus.i_data_ok, 0);
    tick(); bus.m_data_ok = 0;

    // Starvation guard: both requesting on a zero-wait bus -> D,D,I,D,D,I.
    tick();
    bus.i_req = 1; bus.d_req = 1; bus.i_addr = 32'h1000; bus.d_addr = 32'h2000;
    bus.m_addr_ok = 1; bus.m_data_ok = 1; bus.m_rdata = 32'hA5A5A5A5;
    dut_grants.delete(); log_base = grant_log.size(); capture = 1;
    exp_q = '{2'd2, 2'd2, 2'd1, 2'd2, 2'd2, 2'd1};
    repeat (18) tick();
    bus.i_req = 0; bus.d_req = 0; bus.m_addr_ok = 0; bus.m_data_ok = 0; capture = 0;
    check("starve_grant_count", dut_grants.size(), 6);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("starve_dut_grant%0d", k), (k < dut_grants.size()) ? dut_grants[k] : 2'd3, exp_q[k]);
      check($sformatf("starve_model_grant%0d", k),
            (log_base + k < grant_log.size()) ? grant_log[log_base + k] : 3, exp_q[k]);
    end

    // Bus stalls with a spurious m_data_ok during ADDR.
    tick(); bus.d_req = 1; bus.d_wr = 0; bus.d_size = 1; bus.d_addr = 32'h1234; dok_cnt = 0; capture = 1;
    tick(); bus.m_data_ok = 1; bus.m_rdata = 32'hBAD; #1;
    check("stall_m_req1", bus.m_req, 1); check("stall_spurious", bus.d_data_ok, 0);
    tick(); bus.m_data_ok = 0; #1; check("stall_m_req2", bus.m_req, 1);
    tick(); bus.m_addr_ok = 1; #1;
    check("stall_m_req3", bus.m_req, 1); check("stall_d_addr_ok", bus.d_addr_ok, 1);
    tick(); bus.d_req = 0; bus.m_addr_ok = 0; #1;
    check("stall_m_req_drop", bus.m_req, 0); check("stall_busy", busy, 1);
    repeat (3) tick();
    tick(); bus.m_data_ok = 1; bus.m_rdata = 32'h600DF00D; #1;
    check("stall_d_data_ok", bus.d_data_ok, 1); check("stall_d_rdata", bus.d_rdata, 32'h600DF00D);
    tick(); bus.m_data_ok = 0; capture = 0; #1;
    check("stall_one_data_ok", dok_cnt, 1); check("stall_idle", busy, 0);

    // Reset while waiting for data, then a stale response.
    tick(); bus.i_req = 1; bus.i_addr = 32'hBFC00010; bus.m_addr_ok = 1;
    tick(); #1; check("rstdata_i_addr_ok", bus.i_addr_ok, 1);
    tick(); bus.i_req = 0; bus.m_addr_ok = 0; rst = 1; #1; check("rstdata_no_ok", bus.i_data_ok, 0);
    tick(); rst = 0; bus.m_data_ok = 1; bus.m_rdata = 32'h12345678; #1;
    check("rstdata_i_data_ok", bus.i_data_ok, 0); check("rstdata_d_data_ok", bus.d_data_ok, 0);
    check("rstdata_busy", busy, 0); check("rstdata_state", state_dbg, 2'd0);
    check("rstdata_i_rdata", bus.i_rdata, 0);
    tick(); bus.m_data_ok = 0;

    // Requester withdraws before acceptance.
    tick(); bus.d_req = 1; bus.d_addr = 32'h40;
    tick(); bus.d_req = 0; #1;
    check("abort_d_addr_ok", bus.d_addr_ok, 0); check("abort_busy", busy, 1);
    tick(); #1; check("abort_idle", busy, 0);

    // Random traffic against the model.
    i_taken = 0; d_taken = 0;
    repeat (3000) begin
      tick();
      drive_random();
    end
    tick(); rst = 0; drive_zero();
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
